clint_trap_ctrl: RTL and testbench



---
 rtl/clint_trap_ctrl_if.sv | 43 ++++
 rtl/clint_trap_ctrl.sv | 152 +++++++++++++++
 tb/tb_clint_trap_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/clint_trap_ctrl_if.sv
// Bus between the decode/CSR stage and clint_trap_ctrl.
// The master drives events and CSR values; the slave (the trap controller) returns redirects and CSR writes.
interface clint_trap_ctrl_if #(
   parameter int XLEN    = 64,
   parameter int NUM_IRQ = 3
);
   logic [NUM_IRQ-1:0] irq_i;
   logic [XLEN-1:0]    pc_i;
   logic               jump_i;
   logic [XLEN-1:0]    jump_pc_i;
   logic [2:0]         expt_info_i;
   logic [XLEN-1:0]    csr_mstatus_i;
   logic [XLEN-1:0]    csr_mie_i;
   logic [XLEN-1:0]    csr_mtvec_i;
   logic [XLEN-1:0]    csr_mepc_i;

   logic [XLEN-1:0]    clint_int_addr_o;
   logic               clint_int_valid_o;
   logic               clint_hold_o;
   logic [NUM_IRQ-1:0] clint_irq_ack_o;
   logic               clint_mepc_wen_o;
   logic               clint_mcause_wen_o;
   logic               clint_mstatus_wen_o;
   logic [XLEN-1:0]    clint_mepc_wdata_o;
   logic [XLEN-1:0]    clint_mcause_wdata_o;
   logic [XLEN-1:0]    clint_mstatus_wdata_o;

   modport master (
      output irq_i, pc_i, jump_i, jump_pc_i, expt_info_i,
             csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
      input  clint_int_addr_o, clint_int_valid_o, clint_hold_o, clint_irq_ack_o,
             clint_mepc_wen_o, clint_mcause_wen_o, clint_mstatus_wen_o,
             clint_mepc_wdata_o, clint_mcause_wdata_o, clint_mstatus_wdata_o
   );

   modport slave (
      input  irq_i, pc_i, jump_i, jump_pc_i, expt_info_i,
             csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
      output clint_int_addr_o, clint_int_valid_o, clint_hold_o, clint_irq_ack_o,
             clint_mepc_wen_o, clint_mcause_wen_o, clint_mstatus_wen_o,
             clint_mepc_wdata_o, clint_mcause_wdata_o, clint_mstatus_wdata_o
   );
endinterface

// File: rtl/clint_trap_ctrl.sv
// Core-local trap controller: arbitrates ecall/ebreak/interrupts/mret and runs a 3-cycle CSR-write + redirect sequence.
// Optional macro CLINT_VECTOR_EN enables vectored mtvec (mode 2'b01) for interrupts.
module clint_trap_ctrl #(
   parameter int                     XLEN      = 64,
   parameter int                     NUM_IRQ   = 3,
   parameter logic [NUM_IRQ*6-1:0]   IRQ_CODES = {6'd7, 6'd3, 6'd11}
) (
   input logic              clk,
   input logic              rst,
   clint_trap_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, TRAP, MRET, DONE} state_t;

   state_t             r_state;
   logic [XLEN-1:0]    r_mepc;
   logic [XLEN-1:0]    r_mcause;
   logic [NUM_IRQ-1:0] r_take_oh;
   logic [XLEN-1:0]    r_addr;
   logic               r_valid;
   logic [NUM_IRQ-1:0] r_ack;
   logic               r_mepc_wen;
   logic               r_mcause_wen;
   logic               r_mstatus_wen;
   logic [XLEN-1:0]    r_mstatus_wdata;

   logic [NUM_IRQ-1:0] w_irq_en;
   logic [NUM_IRQ-1:0] w_irq_oh;
   logic [5:0]         w_irq_code;
   logic               w_ecall;
   logic               w_ebreak;
   logic               w_mret;
   logic               w_int_any;
   logic               w_is_int;
   logic               w_trap;
   logic               w_event;
   logic [XLEN-1:0]    w_base;
   logic [XLEN-1:0]    w_target;
   logic [XLEN-1:0]    w_trap_mstatus;
   logic [XLEN-1:0]    w_mret_mstatus;

   assign w_ecall  = bus.expt_info_i[2];
   assign w_ebreak = bus.expt_info_i[1];
   assign w_mret   = bus.expt_info_i[0];

   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
         localparam logic [5:0] CODE = IRQ_CODES[gi*6 +: 6];
         assign w_irq_en[gi] = bus.csr_mstatus_i[3] & bus.irq_i[gi] & bus.csr_mie_i[CODE];
      end
   endgenerate

   // Descending scan so the lowest enabled index ends up winning.
   always_comb begin
      w_irq_oh   = '0;
      w_irq_code = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_irq_en[i]) begin
            w_irq_oh   = NUM_IRQ'(1) << i;
            w_irq_code = IRQ_CODES[i*6 +: 6];
         end
      end
   end

   assign w_int_any = |w_irq_en;
   assign w_is_int  = w_int_any & ~w_ecall & ~w_ebreak;
   assign w_trap    = w_ecall | w_ebreak | w_int_any;
   assign w_event   = w_trap | w_mret;

   assign w_base = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
`ifdef CLINT_VECTOR_EN
   // Interrupt flag and code are recovered from the captured mcause.
   assign w_target = (bus.csr_mtvec_i[1:0] == 2'b01 && r_mcause[XLEN-1])
                     ? w_base + (XLEN'(r_mcause[5:0]) << 2) : w_base;
`else
   assign w_target = w_base;
`endif

   always_comb begin
      w_trap_mstatus        = bus.csr_mstatus_i;
      w_trap_mstatus[7]     = bus.csr_mstatus_i[3];
      w_trap_mstatus[3]     = 1'b0;
      w_trap_mstatus[12:11] = 2'b11;
      w_mret_mstatus        = bus.csr_mstatus_i;
      w_mret_mstatus[3]     = bus.csr_mstatus_i[7];
      w_mret_mstatus[7]     = 1'b1;
      w_mret_mstatus[12:11] = 2'b11;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= IDLE;
         r_mepc          <= '0;
         r_mcause        <= '0;
         r_take_oh       <= '0;
         r_addr          <= '0;
         r_valid         <= 1'b0;
         r_ack           <= '0;
         r_mepc_wen      <= 1'b0;
         r_mcause_wen    <= 1'b0;
         r_mstatus_wen   <= 1'b0;
         r_mstatus_wdata <= '0;
      end else begin
         r_valid       <= 1'b0;
         r_ack         <= '0;
         r_mepc_wen    <= 1'b0;
         r_mcause_wen  <= 1'b0;
         r_mstatus_wen <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_trap) begin
                  r_state   <= TRAP;
                  r_mepc    <= (w_is_int && bus.jump_i) ? bus.jump_pc_i : bus.pc_i;
                  r_mcause  <= w_is_int ? {1'b1, {(XLEN-7){1'b0}}, w_irq_code}
                                        : (w_ecall ? XLEN'(11) : XLEN'(3));
                  r_take_oh <= w_is_int ? w_irq_oh : '0;
               end else if (w_mret) begin
                  r_state <= MRET;
               end
            end
            TRAP: begin
               r_state         <= DONE;
               r_mepc_wen      <= 1'b1;
               r_mcause_wen    <= 1'b1;
               r_mstatus_wen   <= 1'b1;
               r_mstatus_wdata <= w_trap_mstatus;
               r_addr          <= w_target;
               r_valid         <= 1'b1;
               r_ack           <= r_take_oh;
            end
            MRET: begin
               r_state         <= DONE;
               r_mstatus_wen   <= 1'b1;
               r_mstatus_wdata <= w_mret_mstatus;
               r_addr          <= bus.csr_mepc_i;
               r_valid         <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.clint_hold_o          = (r_state == IDLE) ? w_event : 1'b1;
   assign bus.clint_int_addr_o      = r_addr;
   assign bus.clint_int_valid_o     = r_valid;
   assign bus.clint_irq_ack_o       = r_ack;
   assign bus.clint_mepc_wen_o      = r_mepc_wen;
   assign bus.clint_mcause_wen_o    = r_mcause_wen;
   assign bus.clint_mstatus_wen_o   = r_mstatus_wen;
   assign bus.clint_mepc_wdata_o    = r_mepc;
   assign bus.clint_mcause_wdata_o  = r_mcause;
   assign bus.clint_mstatus_wdata_o = r_mstatus_wdata;
endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Randomized + directed bench for clint_trap_ctrl against a transaction-level trap model.
module tb_clint_trap_ctrl;
   localparam int XLEN    = 64;
   localparam int NUM_IRQ = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clint_trap_ctrl_if #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) bus ();

   clint_trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct {
      bit          trap;
      bit          mret;
      logic [63:0] mepc;
      logic [63:0] mcause;
      logic [63:0] mst;
      logic [63:0] addr;
      logic [2:0]  ack;
   } exp_t;

   // Reference model: mcause code of each interrupt line, priority by position.
   function automatic exp_t model(input bit ecall, input bit ebreak, input bit mret,
                                  input logic [2:0] irq, input logic [63:0] mst,
                                  input logic [63:0] mie, input logic [63:0] mtvec,
                                  input logic [63:0] mepc_csr, input logic [63:0] pc,
                                  input bit jump, input logic [63:0] jpc);
      exp_t e;
      int codes[3] = '{11, 3, 7};
      int taken = -1;
      int code = 0;
      logic [63:0] base;
      e = '{default: '0};
      base = mtvec & ~64'h3;
      if (!ecall && !ebreak) begin
         for (int i = 0; i < 3; i++)
            if (taken < 0 && mst[3] && irq[i] && mie[codes[i]]) taken = i;
      end
      if (ecall || ebreak || taken >= 0) begin
         e.trap = 1;
         e.mst  = (mst & ~64'h1888) | 64'h1800 | (mst[3] ? 64'h80 : 64'h0);
         if (ecall || ebreak) begin
            code     = ecall ? 11 : 3;
            e.mcause = 64'(code);
            e.mepc   = pc;
            e.addr   = base;
         end else begin
            code     = codes[taken];
            e.mcause = 64'h8000_0000_0000_0000 + 64'(code);
            e.mepc   = jump ? jpc : pc;
            e.ack    = 3'(1 << taken);
            e.addr   = base;
`ifdef CLINT_VECTOR_EN
            if (mtvec[1:0] == 2'b01) e.addr = base + 64'(4 * code);
`endif
         end
      end else if (mret) begin
         e.mret = 1;
         e.mst  = (mst & ~64'h1888) | 64'h1880 | (mst[7] ? 64'h8 : 64'h0);
         e.addr = mepc_csr;
      end
      return e;
   endfunction

   task automatic clear_inputs();
      bus.irq_i = '0; bus.pc_i = '0; bus.jump_i = 0; bus.jump_pc_i = '0;
      bus.expt_info_i = '0; bus.csr_mstatus_i = '0; bus.csr_mie_i = '0;
      bus.csr_mtvec_i = '0; bus.csr_mepc_i = '0;
   endtask

   task automatic run_txn(input bit ecall, input bit ebreak, input bit mret,
                          input logic [2:0] irq, input logic [63:0] mst,
                          input logic [63:0] mie, input logic [63:0] mtvec,
                          input logic [63:0] mepc_csr, input logic [63:0] pc,
                          input bit jump, input logic [63:0] jpc);
      exp_t e;
      bit   ev;
      e  = model(ecall, ebreak, mret, irq, mst, mie, mtvec, mepc_csr, pc, jump, jpc);
      ev = e.trap || e.mret;
      @(negedge clk);
      bus.expt_info_i = {ecall, ebreak, mret}; bus.irq_i = irq;
      bus.csr_mstatus_i = mst; bus.csr_mie_i = mie; bus.csr_mtvec_i = mtvec;
      bus.csr_mepc_i = mepc_csr; bus.pc_i = pc; bus.jump_i = jump; bus.jump_pc_i = jpc;
      #1;
      check_val("hold_n", 64'(bus.clint_hold_o), 64'(ev));
      @(negedge clk);
      check_val("hold_n1", 64'(bus.clint_hold_o), 64'(ev));
      check_val("valid_n1", 64'(bus.clint_int_valid_o), 64'h0);
      @(negedge clk);
      check_val("hold_n2", 64'(bus.clint_hold_o), 64'(ev));
      check_val("valid_n2", 64'(bus.clint_int_valid_o), 64'(ev));
      check_val("mstatus_wen", 64'(bus.clint_mstatus_wen_o), 64'(ev));
      check_val("mepc_wen", 64'(bus.clint_mepc_wen_o), 64'(e.trap));
      check_val("mcause_wen", 64'(bus.clint_mcause_wen_o), 64'(e.trap));
      check_val("irq_ack", 64'(bus.clint_irq_ack_o), 64'(e.ack));
      if (ev) begin
         check_val("int_addr", bus.clint_int_addr_o, e.addr);
         check_val("mstatus_wdata", bus.clint_mstatus_wdata_o, e.mst);
      end
      if (e.trap) begin
         check_val("mepc_wdata", bus.clint_mepc_wdata_o, e.mepc);
         check_val("mcause_wdata", bus.clint_mcause_wdata_o, e.mcause);
      end
      clear_inputs();
      @(negedge clk);
      check_val("hold_n3", 64'(bus.clint_hold_o), 64'h0);
      check_val("valid_n3", 64'(bus.clint_int_valid_o), 64'h0);
      check_val("wen_n3", 64'({bus.clint_mepc_wen_o, bus.clint_mcause_wen_o, bus.clint_mstatus_wen_o}), 64'h0);
      check_val("ack_n3", 64'(bus.clint_irq_ack_o), 64'h0);
      $display("txn %0d: ecall=%0b ebreak=%0b mret=%0b irq=%b mst=0x%0h -> trap=%0b mret=%0b addr=0x%0h mcause=0x%0h",
               n_txn, ecall, ebreak, mret, irq, mst, e.trap, e.mret, e.addr, e.mcause);
      n_txn++;
   endtask

   initial begin
      logic [63:0] r_mst, r_mie, r_mtvec, r_mepc, r_pc, r_jpc;
      int sel;
      clear_inputs();
      #12;
      check_val("rst_hold", 64'(bus.clint_hold_o), 64'h0);
      check_val("rst_valid", 64'(bus.clint_int_valid_o), 64'h0);
      check_val("rst_addr", bus.clint_int_addr_o, 64'h0);
      check_val("rst_mcause", bus.clint_mcause_wdata_o, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases
      run_txn(1, 0, 0, 3'b000, 64'h8, 64'h0, 64'h8000_1000, 64'h0, 64'h8000_0010, 0, 64'h0);
      run_txn(0, 0, 0, 3'b110, 64'h8, 64'h88, 64'h8000_1000, 64'h0, 64'h8000_0020, 0, 64'h0);
      run_txn(0, 0, 0, 3'b100, 64'h8, 64'h80, 64'h8000_1001, 64'h0, 64'h8000_0030, 1, 64'h8000_0200);
      run_txn(0, 0, 1, 3'b000, 64'h1880, 64'h0, 64'h8000_1000, 64'h8000_0044, 64'h0, 0, 64'h0);
      run_txn(0, 0, 0, 3'b111, 64'h0, 64'h888, 64'h8000_1000, 64'h0, 64'h8000_0050, 0, 64'h0);
      run_txn(0, 0, 0, 3'b001, 64'h8, 64'h088, 64'h8000_1000, 64'h0, 64'h8000_0060, 0, 64'h0);
      run_txn(1, 0, 0, 3'b001, 64'h8, 64'h800, 64'h8000_1000, 64'h0, 64'h8000_0070, 0, 64'h0);
      run_txn(0, 1, 1, 3'b000, 64'h0, 64'h0, 64'h8000_2001, 64'h0, 64'h8000_0080, 1, 64'h9000_0000);

      // Reset in the middle of a trap sequence
      @(negedge clk);
      bus.expt_info_i = 3'b100; bus.pc_i = 64'h8000_0090; bus.csr_mstatus_i = 64'h8;
      bus.csr_mtvec_i = 64'h8000_1000;
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      #1;
      check_val("midrst_hold", 64'(bus.clint_hold_o), 64'h0);
      check_val("midrst_wen", 64'({bus.clint_mepc_wen_o, bus.clint_mcause_wen_o, bus.clint_mstatus_wen_o}), 64'h0);
      check_val("midrst_mepc", bus.clint_mepc_wdata_o, 64'h0);
      check_val("midrst_addr", bus.clint_int_addr_o, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_val("postrst_valid", 64'(bus.clint_int_valid_o), 64'h0);
         check_val("postrst_wen", 64'({bus.clint_mepc_wen_o, bus.clint_mcause_wen_o, bus.clint_mstatus_wen_o}), 64'h0);
      end

      // Random traffic
      for (int t = 0; t < 60; t++) begin
         sel     = $urandom_range(0, 7);
         r_mst   = {$urandom, $urandom};
         r_mie   = {$urandom, $urandom};
         r_mtvec = {32'h0, $urandom};
         r_mepc  = {$urandom, $urandom};
         r_pc    = {$urandom, $urandom};
         r_jpc   = {$urandom, $urandom};
         run_txn(sel == 0 || sel == 7, sel == 1, sel == 2 || sel == 7, 3'($urandom_range(0, 7)),
                 r_mst, r_mie, r_mtvec, r_mepc, r_pc, 1'($urandom_range(0, 1)), r_jpc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
